// File: rtl/ram_port_master_if.sv
// Request/response stream and RAM-port signal bundle for ram_port_master.
// master = the engine itself; slave = the client plus the attached RAM port.
interface ram_port_master_if #(
  parameter int WIDTHAD = 16,
  parameter int WIDTH   = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [WIDTHAD-1:0] req_addr;
  logic [WIDTH-1:0]   req_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_rdata;
  logic               busy;
  logic [WIDTHAD-1:0] ram_address;
  logic               ram_wren;
  logic [WIDTH-1:0]   ram_data;
  logic               ram_rden;
  logic [WIDTH-1:0]   ram_q;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_q,
    output req_ready, rsp_valid, rsp_rdata, busy,
           ram_address, ram_wren, ram_data, ram_rden
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, ram_q,
    input  req_ready, rsp_valid, rsp_rdata, busy,
           ram_address, ram_wren, ram_data, ram_rden
  );
endinterface

// File: rtl/ram_port_master.sv
// Drives one block-RAM port from a valid/ready request stream and buffers the
// one-cycle-wide read results in a small FIFO so the response side can stall.
module ram_port_master #(
  parameter int WIDTHAD = 16,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst,
  ram_port_master_if.master   bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic             r_inflight;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_pop;
  logic             w_fire;
  logic             w_rd_fire;
  logic [CW:0]      w_credit;

  assign w_pop     = (r_count != '0) & bus.rsp_ready;
  // A pop in this cycle frees a slot in time for a read issued now.
  assign w_credit  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_fire    = bus.req_valid & bus.req_ready;
  assign w_rd_fire = w_fire & ~bus.req_write;

  assign bus.req_ready   = (w_credit < (CW+1)'(DEPTH));
  assign bus.ram_address = bus.req_addr;
  assign bus.ram_data    = bus.req_wdata;
  assign bus.ram_wren    = w_fire & bus.req_write & ~rst;
  assign bus.ram_rden    = w_rd_fire & ~rst;
  assign bus.rsp_valid   = (r_count != '0);
  assign bus.rsp_rdata   = r_mem[r_rd_ptr];
  assign bus.busy        = r_inflight | (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_inflight <= w_rd_fire;
      if (r_inflight) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + {{(CW-1){1'b0}}, r_inflight} - {{(CW-1){1'b0}}, w_pop};
    end
  end

  // ram_q is only meaningful for the single cycle after a read issues.
  always_ff @(posedge clk) begin
    if (r_inflight) r_mem[r_wr_ptr] <= bus.ram_q;
  end
endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master with a behavioural one-cycle-latency RAM.
module tb_ram_port_master;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  ram_port_master_if #(.WIDTHAD(AW), .WIDTH(DW)) bus();
  ram_port_master #(.WIDTHAD(AW), .WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] ram_mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  // q is garbage except in the cycle after a read, so mistimed captures show up
  always @(posedge clk) begin
    if (bus.ram_wren) ram_mem[bus.ram_address] <= bus.ram_data;
    bus.ram_q <= bus.ram_rden ? ram_mem[bus.ram_address] : 32'hBADBAD00;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic req(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  always @(negedge clk) begin
    if (!rst) chk("no_ovf", 32'(32'(dut.r_count) + 32'(dut.r_inflight) <= DEPTH), 1);
  end

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    req(0, 0, '0, '0);
    #2;
    chk("rst_rdy", bus.req_ready, 1);
    chk("rst_vld", bus.rsp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wren", bus.ram_wren, 0);
    chk("rst_rden", bus.ram_rden, 0);
    chk("rst_count", dut.r_count, 0);
    req(1, 1, 16'h0012, 32'h1111_1111); #1;
    chk("rst_wren_gated", bus.ram_wren, 0);
    req(1, 0, 16'h0012, '0); #1;
    chk("rst_rden_gated", bus.ram_rden, 0);
    req(0, 0, '0, '0);
    @(negedge clk); rst = 1'b0;

    // write then read
    @(negedge clk); req(1, 1, 16'h0012, 32'hDEADBEEF); #1;
    chk("wr_wren", bus.ram_wren, 1);
    chk("wr_rden", bus.ram_rden, 0);
    chk("wr_addr", 32'(bus.ram_address), 32'h0012);
    chk("wr_data", bus.ram_data, 32'hDEADBEEF);
    @(negedge clk); req(1, 0, 16'h0012, '0); #1;
    chk("rd_wren", bus.ram_wren, 0);
    chk("rd_rden", bus.ram_rden, 1);
    @(negedge clk); req(0, 0, '0, '0); #1;
    chk("t1_wait_vld", bus.rsp_valid, 0);
    chk("t1_wait_busy", bus.busy, 1);
    chk("t1_wait_wren", bus.ram_wren, 0);
    @(negedge clk); #1;
    chk("t1_vld", bus.rsp_valid, 1);
    chk("t1_data", bus.rsp_rdata, 32'hDEADBEEF);
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("t1_pop_vld", bus.rsp_valid, 0);
    chk("t1_pop_busy", bus.busy, 0);

    // preload and stream 8 reads
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); req(1, 1, AW'(i), DW'(3 * i)); #1;
      chk("pre_rdy", bus.req_ready, 1);
      chk("pre_wren", bus.ram_wren, 1);
    end
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k < 8) req(1, 0, AW'(k), '0);
      else       req(0, 0, '0, '0);
      #1;
      if (k < 8) chk("str_rdy", bus.req_ready, 1);
      chk("str_vld", bus.rsp_valid, 32'(k >= 2 && k < 10));
      if (k >= 2 && k < 10) chk("str_data", bus.rsp_rdata, 32'(3 * (k - 2)));
    end

    // backpressure
    @(negedge clk); bus.rsp_ready = 1'b0; req(1, 0, 16'd1, '0); #1;
    chk("bp_rdy1", bus.req_ready, 1);
    @(negedge clk); req(1, 0, 16'd2, '0); #1;
    chk("bp_rdy2", bus.req_ready, 1);
    @(negedge clk); req(1, 0, 16'd3, '0); #1;
    chk("bp_rdy3", bus.req_ready, 0);
    chk("bp_rden3", bus.ram_rden, 0);
    @(negedge clk); #1;
    chk("bp_hold_rdy", bus.req_ready, 0);
    chk("bp_hold_vld", bus.rsp_valid, 1);
    chk("bp_data1", bus.rsp_rdata, 32'd3);
    bus.rsp_ready = 1'b1; #1;
    chk("bp_release_rdy", bus.req_ready, 1);
    chk("bp_release_rden", bus.ram_rden, 1);
    @(negedge clk); req(0, 0, '0, '0); #1;
    chk("bp_data2", bus.rsp_rdata, 32'd6);
    @(negedge clk); #1;
    chk("bp_data3", bus.rsp_rdata, 32'd9);
    @(negedge clk); #1;
    chk("bp_end_vld", bus.rsp_valid, 0);
    chk("bp_end_busy", bus.busy, 0);

    // full with simultaneous capture and pop
    @(negedge clk); bus.rsp_ready = 1'b0; req(1, 0, 16'd6, '0); #1;
    chk("fp_rdy1", bus.req_ready, 1);
    @(negedge clk); req(1, 0, 16'd7, '0); #1;
    chk("fp_rdy2", bus.req_ready, 1);
    @(negedge clk); req(1, 0, 16'd0, '0); #1;
    chk("fp_stall_rdy", bus.req_ready, 0);
    chk("fp_count_pre", dut.r_count, 1);
    chk("fp_infl_pre", dut.r_inflight, 1);
    chk("fp_data1", bus.rsp_rdata, 32'd18);
    bus.rsp_ready = 1'b1; #1;
    chk("fp_pop_rdy", bus.req_ready, 1);
    @(negedge clk); req(0, 0, '0, '0); #1;
    chk("fp_count", dut.r_count, 1);
    chk("fp_infl", dut.r_inflight, 1);
    chk("fp_data2", bus.rsp_rdata, 32'd21);
    @(negedge clk); #1;
    chk("fp_count2", dut.r_count, 1);
    chk("fp_data3", bus.rsp_rdata, 32'd0);
    @(negedge clk); #1;
    chk("fp_end_vld", bus.rsp_valid, 0);
    chk("fp_end_busy", bus.busy, 0);

    // reset in the capture cycle
    @(negedge clk); req(1, 0, 16'd3, '0); #1;
    chk("rm_rdy", bus.req_ready, 1);
    @(negedge clk); req(1, 0, 16'd2, '0); rst = 1'b1; #1;
    chk("rm_rden", bus.ram_rden, 0);
    chk("rm_busy", bus.busy, 0);
    chk("rm_rdy_in_rst", bus.req_ready, 1);
    chk("rm_vld_in_rst", bus.rsp_valid, 0);
    @(negedge clk); req(0, 0, '0, '0); rst = 1'b0; #1;
    chk("rm_vld", bus.rsp_valid, 0);
    chk("rm_busy_rel", bus.busy, 0);
    chk("rm_rdy_rel", bus.req_ready, 1);
    @(negedge clk); #1;
    chk("rm_vld2", bus.rsp_valid, 0);
    chk("rm_busy2", bus.busy, 0);
    @(negedge clk); req(1, 0, 16'd3, '0); #1;
    chk("rm_rd_rden", bus.ram_rden, 1);
    @(negedge clk); req(0, 0, '0, '0);
    @(negedge clk); #1;
    chk("rm_rd_vld", bus.rsp_valid, 1);
    chk("rm_rd_data", bus.rsp_rdata, 32'd9);

    // write held while credit is exhausted
    @(negedge clk); bus.rsp_ready = 1'b0; req(1, 0, 16'd4, '0); #1;
    chk("ws_rdy1", bus.req_ready, 1);
    @(negedge clk); req(1, 0, 16'd5, '0); #1;
    chk("ws_rdy2", bus.req_ready, 1);
    @(negedge clk); req(1, 1, 16'h0040, 32'hCAFE0001); #1;
    chk("ws_stall_rdy", bus.req_ready, 0);
    chk("ws_stall_wren", bus.ram_wren, 0);
    @(negedge clk); #1;
    chk("ws_stall_rdy2", bus.req_ready, 0);
    chk("ws_stall_wren2", bus.ram_wren, 0);
    chk("ws_data1", bus.rsp_rdata, 32'd12);
    bus.rsp_ready = 1'b1; #1;
    chk("ws_go_rdy", bus.req_ready, 1);
    chk("ws_go_wren", bus.ram_wren, 1);
    @(negedge clk); req(0, 0, '0, '0); #1;
    chk("ws_after_wren", bus.ram_wren, 0);
    chk("ws_data2", bus.rsp_rdata, 32'd15);
    @(negedge clk); #1;
    chk("ws_no_rsp_vld", bus.rsp_valid, 0);
    chk("ws_no_rsp_busy", bus.busy, 0);
    @(negedge clk); #1;
    chk("ws_no_rsp_vld2", bus.rsp_valid, 0);
    @(negedge clk); req(1, 0, 16'h0040, '0); #1;
    chk("ws_rd_rden", bus.ram_rden, 1);
    @(negedge clk); req(0, 0, '0, '0);
    @(negedge clk); #1;
    chk("ws_rd_vld", bus.rsp_valid, 1);
    chk("ws_rd_data", bus.rsp_rdata, 32'hCAFE0001);
    @(negedge clk); #1;
    chk("ws_end_vld", bus.rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_port_master.md
# ram_port_master

Requester-side engine for one port of the team's dual-port block RAM wrapper (registered address/data/control, unregistered `q`, one-cycle read latency). It accepts a valid/ready request stream of reads and writes, drives the RAM port signals, and captures each one-cycle-wide read result into a small response FIFO. The response leaves on a valid/ready stream, so consumers can apply backpressure without losing data. One instance sits in front of each RAM port a client owns, for example CPU load/store or DMA.

## Interface
- `WIDTHAD`, 16, address width; must match the attached RAM.
- `WIDTH`, 32, data width; must match the attached RAM.
- `DEPTH`, 2, response FIFO entries; power of two, ≥2.

- `clk`  in  1  single clock, rising edge; the same clock as the RAM.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high together with `req_valid` (a "fire").
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  WIDTHAD  word address.
- `req_wdata`  in  WIDTH  write data.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  WIDTH  read data, in request order.
- `busy`  out  1  high when any read is in flight or buffered.
- `ram_address`  out  WIDTHAD  to RAM `address`.
- `ram_wren`  out  1  to RAM `wren`.
- `ram_data`  out  WIDTH  to RAM `data`.
- `ram_rden`  out  1  to RAM `rden`.
- `ram_q`  in  WIDTH  from RAM `q`; valid only in the cycle after a read is issued.

## Operation
- `ram_address` = `req_addr` and `ram_data` = `req_wdata` at all times.
- On a write fire: `ram_wren`=1 and `ram_rden`=0. Otherwise `ram_wren`=0.
- On a read fire: `ram_rden`=1 and `ram_wren`=0. Otherwise `ram_rden`=0.
- No fire → both strobes 0. Strobes are 0 while `rst` is high.
- State:
  - `inflight` (1 bit): set at the clock edge of a read fire, cleared otherwise.
  - `count` (0..DEPTH): FIFO occupancy.
  - `pop` = `rsp_valid` & `rsp_ready`.
- Capture: when `inflight`=1, `ram_q` is written into the FIFO tail at that edge. The capture is unconditional; the credit rule below guarantees space.
- Credit rule: `req_ready` = (`count` + `inflight` − `pop`) < DEPTH.
  - It applies to both reads and writes and does not depend on `req_valid` or `req_write`.
  - It is combinational from `rsp_ready`.
  - Writes produce no response.
- `rsp_valid` = (`count` ≠ 0). `rsp_rdata` = FIFO head, registered.
- `busy` = `inflight` | (`count` ≠ 0).
- Count update each edge: `count` += (`inflight` ? 1 : 0) − (`pop` ? 1 : 0). Capture and pop in the same edge are allowed, including at `count`=DEPTH, where the net change is 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Overflow and underflow are impossible by construction; the bench asserts this.
- Ordering: responses return strictly in read-issue order. A read after a write to the same address, issued at least one cycle later, returns the new data.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `busy`=0, `ram_wren`=0, `ram_rden`=0, `count`=0, `inflight`=0. `rsp_rdata` is don't-care.
- A write fired at edge N is committed in the RAM at edge N.
- A read fired at edge N: `ram_q` is valid in cycle N+1 and captured at edge N+1. `rsp_valid` first goes high in cycle N+2 (read-to-response latency 2).
- Throughput: with `rsp_ready`=1 continuously, one read per cycle is sustained with DEPTH=2.
- Backpressure: with `rsp_ready`=0, `req_ready` falls once `count` + `inflight` = DEPTH. No `ram_q` word is ever dropped.
- Reset mid-operation: the in-flight read and all buffered responses are discarded. Writes fired before the reset remain committed in the RAM.
- Asynchronous assertion of `rst` forces the strobes to 0 immediately. Deassertion is synchronous to `clk`.

## Test plan
- Write then read:
  - Stimulus: write 0xDEADBEEF to 0x0012 at edge 1; read 0x0012 at edge 2.
  - Required: `ram_wren` high only in cycle 1; `rsp_valid` high in cycle 4 with `rsp_rdata`=0xDEADBEEF.
- Streaming reads:
  - Stimulus: preload addresses 0..7 with value = address × 3; issue 8 back-to-back reads with `rsp_ready`=1.
  - Required: `req_ready` never drops; responses 0,3,…,21 arrive in 8 consecutive cycles starting 2 cycles after the first fire.
- Backpressure:
  - Stimulus: `rsp_ready`=0; issue 3 reads (addresses 1, 2, 3).
  - Required: the first 2 are accepted and the third stalls with `req_ready`=0. After `rsp_ready`=1, the third is accepted in the same cycle as the first pop, and all 3 return in order.
- Full plus simultaneous capture and pop:
  - Stimulus: with `count`=1 and `inflight`=1, hold `rsp_ready`=1 and `req_valid`=1 (read).
  - Required: `req_ready`=1, `count` stays at 1, no overflow assertion fires.
- Reset mid-flight:
  - Stimulus: issue a read, then assert `rst` in the capture cycle.
  - Required: `rsp_valid` stays 0, `busy`=0 and `req_ready`=1 after release. A subsequent read returns the correct data.
- Write during stall:
  - Stimulus: at full credit, assert a write request.
  - Required: the write is held (`ram_wren`=0) until `req_ready`=1. The write then commits and no response is produced.
